// File: rtl/mpmc9_wdf_strip_sender.sv
// Write-data source for the MIG write-data FIFO: streams up to 2^SW staged strips
// as registered beats, holding each beat until the MIG accepts it.
//
// state  | meaning
// IDLE   | waiting for start; strip_idx parked at 0 so strip 0 is already presented
// SEND   | a beat is valid on the MIG port; advance on app_wdf_rdy
// DONE   | final beat accepted; done pulses for this one cycle
module mpmc9_wdf_strip_sender #(
    parameter int WID = 128,
    parameter int SW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SW-1:0]    num_strips,
    input  logic [WID-1:0]   data_i,
    input  logic [WID/8-1:0] mask_i,
    output logic [SW-1:0]    strip_idx,
    input  logic             app_wdf_rdy,
    output logic [WID-1:0]   app_wdf_data,
    output logic [WID/8-1:0] app_wdf_mask,
    output logic             app_wdf_wren,
    output logic             app_wdf_end,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [SW-1:0]     last, last_n;
    logic [SW-1:0]     cnt, cnt_n;
    logic [SW-1:0]     idx_n;
    logic [WID-1:0]    data_n;
    logic [WID/8-1:0]  mask_n;
    logic              wren_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            last         <= '0;
            cnt          <= '0;
            strip_idx    <= '0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
            app_wdf_wren <= 1'b0;
        end else begin
            state        <= state_n;
            last         <= last_n;
            cnt          <= cnt_n;
            strip_idx    <= idx_n;
            app_wdf_data <= data_n;
            app_wdf_mask <= mask_n;
            app_wdf_wren <= wren_n;
        end
    end

    always_comb begin
        state_n = state;
        last_n  = last;
        cnt_n   = cnt;
        idx_n   = strip_idx;
        data_n  = app_wdf_data;
        mask_n  = app_wdf_mask;
        wren_n  = app_wdf_wren;
        case (state)
            S_IDLE: begin
                if (start) begin
                    last_n  = num_strips;
                    data_n  = data_i;
                    mask_n  = mask_i;
                    wren_n  = 1'b1;
                    idx_n   = SW'(1);
                    cnt_n   = '0;
                    state_n = S_SEND;
                end
            end
            S_SEND: begin
                // Everything holds while the MIG is not ready.
                if (app_wdf_wren && app_wdf_rdy) begin
                    if (cnt == last) begin
                        wren_n  = 1'b0;
                        idx_n   = '0;
                        state_n = S_DONE;
                    end else begin
                        data_n = data_i;
                        mask_n = mask_i;
                        idx_n  = strip_idx + SW'(1);
                        cnt_n  = cnt + SW'(1);
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                wren_n  = 1'b0;
                idx_n   = '0;
            end
        endcase
    end

    // 4:1 mode: every beat is a complete MIG burst.
    assign app_wdf_end = app_wdf_wren;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

endmodule

// File: tb/tb_mpmc9_wdf_strip_sender.sv
// Self-checking bench for mpmc9_wdf_strip_sender: table-driven bursts, hand-written
// corner sequences and randomized bursts against a beat-sequence reference model.
module tb_mpmc9_wdf_strip_sender;

    localparam int WID = 128;
    localparam int SW  = 3;
    localparam int NS  = 1 << SW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [SW-1:0]    num_strips = '0;
    logic [WID-1:0]   data_i;
    logic [WID/8-1:0] mask_i;
    logic [SW-1:0]    strip_idx;
    logic             app_wdf_rdy = 1'b1;
    logic [WID-1:0]   app_wdf_data;
    logic [WID/8-1:0] app_wdf_mask;
    logic             app_wdf_wren;
    logic             app_wdf_end;
    logic             busy;
    logic             done;

    logic [WID-1:0]   strip_data [NS];
    logic [WID/8-1:0] strip_mask [NS];

    int compared   = 0;
    int mismatched = 0;

    // Upstream staging buffer: combinational read by strip_idx.
    assign data_i = strip_data[strip_idx];
    assign mask_i = strip_mask[strip_idx];

    always #5 clk = ~clk;

    mpmc9_wdf_strip_sender #(.WID(WID), .SW(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_strips   (num_strips),
        .data_i       (data_i),
        .mask_i       (mask_i),
        .strip_idx    (strip_idx),
        .app_wdf_rdy  (app_wdf_rdy),
        .app_wdf_data (app_wdf_data),
        .app_wdf_mask (app_wdf_mask),
        .app_wdf_wren (app_wdf_wren),
        .app_wdf_end  (app_wdf_end),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        int          n;
        logic [31:0] stall;     // bit c set: rdy low in cycle c
        int          exp_done;  // expected done cycle
        int          fill;      // 0: A5 pattern, 1: k replicated, 2: mask test
        bit          inject;    // pulse start during SEND and DONE
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [WID-1:0] act, input logic [WID-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_strips(input int mode);
        for (int k = 0; k < NS; k++) begin
            case (mode)
                0: begin strip_data[k] = {16{8'hA5}};   strip_mask[k] = '0; end
                1: begin strip_data[k] = {16{8'(k)}};   strip_mask[k] = '0; end
                2: begin
                    strip_data[k] = {4{$urandom}};
                    strip_mask[k] = (k == 0) ? 16'hFFFF : 16'h000F;
                end
                default: begin
                    strip_data[k] = {$urandom, $urandom, $urandom, $urandom};
                    strip_mask[k] = 16'($urandom);
                end
            endcase
        end
    endtask

    // Caller is positioned just after a rising edge. Model: beat k (0..n) is strip k,
    // strip_idx shows the next strip (k+1 mod 2^SW); each accept advances k; the
    // done cycle is 1 + (n+1) + stall cycles, followed by a cycle back in IDLE.
    task automatic run_burst(input string tag, input int n, input logic [31:0] stall,
                             input int exp_done, input bit rand_rdy, input bit inject);
        int  k = 0;
        int  cyc = 1;
        int  stalls = 0;
        bit  finished = 0;
        start = 1'b1;
        num_strips = SW'(n);
        app_wdf_rdy = 1'b1;
        @(negedge clk);
        chk({tag, " idle_busy"}, WID'(busy), '0);
        chk({tag, " idle_idx"}, WID'(strip_idx), '0);
        @(posedge clk); #1;
        start = 1'b0;
        while (!finished && cyc < 200) begin
            app_wdf_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : !stall[cyc % 32];
            if (inject) begin
                start = 1'b1;
                num_strips = SW'(5);
            end
            @(negedge clk);
            if (k <= n) begin
                chk({tag, " wren"}, WID'(app_wdf_wren), WID'(1));
                chk({tag, " end"}, WID'(app_wdf_end), WID'(1));
                chk({tag, " data"}, app_wdf_data, strip_data[k]);
                chk({tag, " mask"}, WID'(app_wdf_mask), WID'(strip_mask[k]));
                chk({tag, " idx"}, WID'(strip_idx), WID'((k + 1) % NS));
                chk({tag, " busy"}, WID'(busy), WID'(1));
                chk({tag, " done_early"}, WID'(done), '0);
            end else begin
                chk({tag, " done"}, WID'(done), WID'(1));
                chk({tag, " done_wren"}, WID'(app_wdf_wren), '0);
                chk({tag, " done_idx"}, WID'(strip_idx), '0);
                chk({tag, " done_busy"}, WID'(busy), WID'(1));
                chk({tag, " done_cycle_model"}, WID'(cyc), WID'(n + 2 + stalls));
                if (exp_done >= 0) chk({tag, " done_cycle"}, WID'(cyc), WID'(exp_done));
                finished = 1;
            end
            @(posedge clk);
            if (k <= n) begin
                if (app_wdf_rdy) k++;
                else stalls++;
            end
            #1;
            cyc++;
        end
        if (!finished) chk({tag, " timeout"}, WID'(cyc), '0);
        start = 1'b0;
        app_wdf_rdy = 1'b1;
        @(negedge clk);
        chk({tag, " back_idle_busy"}, WID'(busy), '0);
        chk({tag, " back_idle_done"}, WID'(done), '0);
        chk({tag, " back_idle_wren"}, WID'(app_wdf_wren), '0);
        @(posedge clk); #1;
        // An ignored start must not have launched a second burst.
        @(negedge clk);
        chk({tag, " no_second_burst"}, WID'(busy), '0);
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0] = '{n: 0, stall: 32'h0,  exp_done: 2, fill: 0, inject: 0};
        tbl[1] = '{n: 7, stall: 32'h0,  exp_done: 9, fill: 1, inject: 0};
        tbl[2] = '{n: 3, stall: 32'h1C, exp_done: 8, fill: 1, inject: 0};
        tbl[3] = '{n: 1, stall: 32'h0,  exp_done: 3, fill: 1, inject: 1};
        tbl[4] = '{n: 1, stall: 32'h0,  exp_done: 3, fill: 2, inject: 0};
        fill_strips(0);

        #2;
        chk("rst_wren", WID'(app_wdf_wren), '0);
        chk("rst_end", WID'(app_wdf_end), '0);
        chk("rst_busy", WID'(busy), '0);
        chk("rst_done", WID'(done), '0);
        chk("rst_idx", WID'(strip_idx), '0);
        chk("rst_data", app_wdf_data, '0);
        chk("rst_mask", WID'(app_wdf_mask), '0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            fill_strips(tbl[i].fill);
            run_burst($sformatf("vec%0d", i), tbl[i].n, tbl[i].stall,
                      tbl[i].exp_done, 1'b0, tbl[i].inject);
        end

        // Asynchronous reset between edges while beat 2 of an 8-strip burst is up.
        fill_strips(1);
        start = 1'b1;
        num_strips = SW'(7);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_beat2_data", app_wdf_data, strip_data[2]);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_wren", WID'(app_wdf_wren), '0);
        chk("arst_end", WID'(app_wdf_end), '0);
        chk("arst_busy", WID'(busy), '0);
        chk("arst_idx", WID'(strip_idx), '0);
        chk("arst_done", WID'(done), '0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        fill_strips(3);
        run_burst("after_rst", 1, 32'h0, 3, 1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            fill_strips(3);
            run_burst($sformatf("rand%0d", r), $urandom_range(0, NS - 1), 32'h0, -1, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mpmc9_wdf_strip_sender.md
# mpmc9_wdf_strip_sender

Write-data source for the MIG write-data FIFO in the mpmc9 multi-port memory controller. For an accepted write request, the block reads up to eight 128-bit strips from the port's staging buffer. It presents them to the MIG write-data port as a sequence of beats, holding each beat stable until the MIG accepts it. The write-command path that issues `app_cmd`/`app_en` is a separate block; this one owns only the write-data port.

## Interface

**Parameters**
- `WID`, default 128: MIG application data width in bits; `WID` is a multiple of 8.
- `SW`, default 3: strip-count/index width; maximum burst is 2^SW strips.

**Ports** (name, direction, width, meaning)
- `clk` in 1: controller clock, the MIG `ui_clk` domain.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to send a burst; honoured only in IDLE.
- `num_strips` in SW: number of strips minus one (0 means 1 beat, 7 means 8 beats); sampled with `start`.
- `data_i` in WID: strip data. The upstream buffer drives it combinationally from `strip_idx`.
- `mask_i` in WID/8: byte mask for `data_i`, also indexed by `strip_idx`; 1 means the byte is not written.
- `strip_idx` out SW: registered index of the strip to be loaded next.
- `app_wdf_rdy` in 1: MIG write-data FIFO ready.
- `app_wdf_data` out WID: registered beat data.
- `app_wdf_mask` out WID/8: registered beat mask.
- `app_wdf_wren` out 1: beat valid.
- `app_wdf_end` out 1: last beat of a MIG burst. In 4:1 mode every beat is a full burst, so it is always equal to `app_wdf_wren`.
- `busy` out 1: the state is not IDLE.
- `done` out 1: one-cycle pulse after the final beat is accepted.

## Operation

**States:** IDLE, SEND, DONE. Encoding is local to this block.

**IDLE**
- `strip_idx` is 0, so the upstream buffer is already presenting strip 0.
- On `start`:
  - `last` <= `num_strips`
  - `app_wdf_data` <= `data_i`, `app_wdf_mask` <= `mask_i`
  - `app_wdf_wren` <= 1, `app_wdf_end` <= 1
  - `strip_idx` <= 1
  - beat counter `cnt` <= 0
  - go to SEND

**SEND**
- A beat is accepted on a clock edge where `app_wdf_wren` and `app_wdf_rdy` are both 1.
- While `app_wdf_rdy` is 0, all outputs hold. Data, mask and `strip_idx` must not change.
- On acceptance with `cnt` != `last`:
  - load `data_i`/`mask_i` into the beat registers
  - `strip_idx` += 1, `cnt` += 1
  - `wren`/`end` stay 1
- On acceptance with `cnt` == `last`:
  - `wren` <= 0, `end` <= 0
  - `strip_idx` <= 0
  - `done` <= 1
  - go to DONE

**DONE**
- `done` is 1 for exactly this cycle. Go to IDLE and clear `done`.
- `start` in DONE is ignored and is not queued.

**Arithmetic and boundaries**
- `cnt` and `strip_idx` are SW bits wide. `strip_idx` wraps from 7 to 0 on the final beat of an 8-strip burst, which matches the forced 0.
- `start` asserted in SEND or DONE is ignored, and `num_strips` is not re-sampled.
- `app_wdf_data`/`app_wdf_mask` retain their last values when `wren` is 0. Their contents are don't-care then.

**Reset** (asynchronous, any state, including mid-burst)
- State goes to IDLE.
- `app_wdf_wren`, `app_wdf_end`, `busy`, `done`, `strip_idx`, `cnt`, `app_wdf_data`, `app_wdf_mask` all go to 0.
- A partially sent burst is abandoned. Recovering the MIG side is the controller's responsibility.

## Timing

- `start` sampled at edge 0 puts beat 0 on the MIG port in cycle 1. Latency from `start` to first `wren` is one cycle.
- With `app_wdf_rdy` held at 1, beats are back to back: `wren` is high in cycles 1 through N+1, where N = `num_strips`.
- `done` is high in cycle N+2, and the block is back in IDLE in cycle N+3.
- Each cycle with `rdy` low while `wren` is high adds exactly one cycle to the burst.
- `busy` is high in cycles 1 through N+2.
- The earliest next `start` accepted is in cycle N+3.
- Upstream must present `data_i` for the current `strip_idx` combinationally, within the same cycle.

## Test plan

1. **Single beat:** `num_strips`=0, strip 0 = 0xA5…A5, mask 0, `rdy`=1. Expect one `wren`/`end` beat with data A5…A5 in cycle 1, `done` in cycle 2, `strip_idx` back to 0.
2. **Full burst, no stall:** `num_strips`=7, strip k = k replicated. Expect 8 consecutive beats with data 0..7, `end`=1 on each, `done` in cycle 9, `strip_idx` wrapped to 0.
3. **Backpressure:** `num_strips`=3, `rdy` low in cycles 2–4. Expect beat 1 held constant for 3 extra cycles with `strip_idx` frozen at 2, the 4 beats delivered in order, `done` in cycle 8.
4. **Ignored start:** pulse `start` with `num_strips`=5 during SEND of a 2-strip burst, and again in the DONE cycle. Expect exactly 2 beats and no second burst.
5. **Reset mid-burst:** assert `rst` asynchronously between edges during beat 2 of an 8-strip burst. Expect `wren`, `end`, `busy` and `strip_idx` at 0 immediately. After release, a new `start` with `num_strips`=1 yields a clean 2-beat burst starting at strip 0.
6. **Byte mask pass-through:** strip masks 0xFFFF and 0x000F with `num_strips`=1. Expect `app_wdf_mask` = 0xFFFF on beat 0 and 0x000F on beat 1.
